logic_op_pipe: RTL and testbench

LOGIC_OP_PIPE -- requirements
Module: logic_op_pipe

---
 rtl/logic_op_pipe.sv | 167 ++++++++++++++++
 tb/tb_logic_op_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready pipeline applying a bitwise logic op to operands a/b.
// Optional build macro LOGIC_OP_PIPE_PARITY_EN adds a registered result parity output.
module logic_op_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             op_err,
  output logic             res_zero,
`ifdef LOGIC_OP_PIPE_PARITY_EN
  output logic             parity,
`endif
  output logic [15:0]      txn_cnt
);

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NOT_A = 3'd2,
    OP_XOR   = 3'd3,
    OP_XNOR  = 3'd4,
    OP_NAND  = 3'd5,
    OP_ILL6  = 3'd6,
    OP_ILL7  = 3'd7
  } op_e;

  // Stage 1: captured operands
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  op_e              s1_op_q, s1_op_d;

  // Stage 2: computed result and flags
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d;
  logic             s2_err_q, s2_err_d;
  logic             s2_zero_q, s2_zero_d;
`ifdef LOGIC_OP_PIPE_PARITY_EN
  logic             s2_par_q, s2_par_d;
`endif

  logic [15:0]      cnt_q, cnt_d;

  logic             in_hs;
  logic             out_hs;
  logic             s2_load;
  logic [WIDTH-1:0] calc_res;
  logic             calc_err;

  // S1 advances whenever S2 is free or draining; in_ready never looks at in_valid
  always_comb begin
    out_hs   = s2_valid_q && out_ready;
    s2_load  = s1_valid_q && (!s2_valid_q || out_hs);
    in_ready = !s1_valid_q || s2_load;
    in_hs    = in_valid && in_ready;
  end

  always_comb begin
    calc_res = '0;
    calc_err = 1'b0;
    unique case (s1_op_q)
      OP_AND:   calc_res = s1_a_q & s1_b_q;
      OP_OR:    calc_res = s1_a_q | s1_b_q;
      OP_NOT_A: calc_res = ~s1_a_q;
      OP_XOR:   calc_res = s1_a_q ^ s1_b_q;
      OP_XNOR:  calc_res = ~(s1_a_q ^ s1_b_q);
      OP_NAND:  calc_res = ~(s1_a_q & s1_b_q);
      OP_ILL6,
      OP_ILL7: begin
        calc_res = '0;
        calc_err = 1'b1;
      end
      default: begin
        calc_res = '0;
        calc_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_err_d   = s2_err_q;
    s2_zero_d  = s2_zero_q;
`ifdef LOGIC_OP_PIPE_PARITY_EN
    s2_par_d   = s2_par_q;
`endif
    cnt_d      = cnt_q;

    if (in_hs) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      s1_b_d     = b;
      s1_op_d    = op_e'(op);
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_res_d   = calc_res;
      s2_err_d   = calc_err;
      s2_zero_d  = (calc_res == '0);
`ifdef LOGIC_OP_PIPE_PARITY_EN
      s2_par_d   = ^calc_res;
`endif
    end else if (out_hs) begin
      s2_valid_d = 1'b0;
    end

    if (out_hs) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_AND;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_err_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
`ifdef LOGIC_OP_PIPE_PARITY_EN
      s2_par_q   <= 1'b0;
`endif
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_err_q   <= s2_err_d;
      s2_zero_q  <= s2_zero_d;
`ifdef LOGIC_OP_PIPE_PARITY_EN
      s2_par_q   <= s2_par_d;
`endif
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_res_q;
  assign op_err    = s2_err_q;
  assign res_zero  = s2_zero_q;
`ifdef LOGIC_OP_PIPE_PARITY_EN
  assign parity    = s2_par_q;
`endif
  assign txn_cnt   = cnt_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe: vector table, stall/reset sequences,
// random traffic with random backpressure, and txn_cnt wrap, all through a scoreboard.
module tb_logic_op_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  result;
  logic        op_err;
  logic        res_zero;
  logic [15:0] txn_cnt;
`ifdef LOGIC_OP_PIPE_PARITY_EN
  logic        parity;
`endif

  logic_op_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .op_err    (op_err),
    .res_zero  (res_zero),
`ifdef LOGIC_OP_PIPE_PARITY_EN
    .parity    (parity),
`endif
    .txn_cnt   (txn_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       err;
    logic       zero;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [2:0] vop;
    logic [7:0] res;
    logic       err;
    logic       zero;
  } vec_t;

  exp_t        sb[$];
  exp_t        cur_exp;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          pop_cnt  = 0;
  logic [15:0] exp_cnt  = '0;
  logic        chk_lat  = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %0s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Independent bit-serial reference; codes 6/7 produce zero
  function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      case (o)
        3'd0:    r[i] = x[i] & y[i];
        3'd1:    r[i] = x[i] | y[i];
        3'd2:    r[i] = !x[i];
        3'd3:    r[i] = x[i] != y[i];
        3'd4:    r[i] = x[i] == y[i];
        3'd5:    r[i] = !(x[i] & y[i]);
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: push on input handshake, pop and compare on output handshake
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      sb.delete();
      exp_cnt = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got result %0h, required no output", result);
        end else begin
          e = sb.pop_front();
          pop_cnt++;
          chk("result", result, e.res);
          chk("op_err", op_err, e.err);
          chk("res_zero", res_zero, e.zero);
`ifdef LOGIC_OP_PIPE_PARITY_EN
          chk("parity", parity, ^e.res);
`endif
          if (chk_lat) chk("latency", cyc - e.cyc, 2);
        end
        chk("txn_cnt", txn_cnt, exp_cnt);
        exp_cnt = exp_cnt + 16'd1;
      end
      if (in_valid && in_ready) begin
        e     = cur_exp;
        e.cyc = cyc;
        sb.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge
  task automatic send(input logic [7:0] ta, input logic [7:0] tbv, input logic [2:0] top,
                      input logic [7:0] eres, input logic eerr, input logic ezero);
    int n;
    a        = ta;
    b        = tbv;
    op       = top;
    cur_exp  = '{res: eres, err: eerr, zero: ezero, cyc: 0};
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready got 0, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    chk(nm, sb.size(), 0);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    int p0;
    logic [7:0] ra, rb;
    logic [2:0] rop;

    vecs[0]  = '{8'hA5, 8'h3C, 3'd3, 8'h99, 1'b0, 1'b0};
    vecs[1]  = '{8'hA5, 8'h3C, 3'd0, 8'h24, 1'b0, 1'b0};
    vecs[2]  = '{8'hA5, 8'h3C, 3'd1, 8'hBD, 1'b0, 1'b0};
    vecs[3]  = '{8'hA5, 8'h3C, 3'd2, 8'h5A, 1'b0, 1'b0};
    vecs[4]  = '{8'hA5, 8'h3C, 3'd4, 8'h66, 1'b0, 1'b0};
    vecs[5]  = '{8'hA5, 8'h3C, 3'd5, 8'hDB, 1'b0, 1'b0};
    vecs[6]  = '{8'hFF, 8'hFF, 3'd6, 8'h00, 1'b1, 1'b1};
    vecs[7]  = '{8'hA5, 8'h3C, 3'd7, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{8'hFF, 8'h00, 3'd2, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{8'h00, 8'h00, 3'd4, 8'hFF, 1'b0, 1'b0};
    vecs[10] = '{8'hA5, 8'hA5, 3'd3, 8'h00, 1'b0, 1'b1};
    vecs[11] = '{8'h01, 8'h00, 3'd1, 8'h01, 1'b0, 1'b0};

    rst       = 1'b1;
    out_ready = 1'b1;
    a         = 8'hFF;
    b         = 8'hFF;
    op        = 3'd0;
    cur_exp   = '{res: 8'hFF, err: 1'b0, zero: 1'b0, cyc: 0};
    // in_valid held high through reset must not be captured
    in_valid  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_op_err", op_err, 0);
    chk("rst_res_zero", res_zero, 0);
    chk("rst_txn_cnt", txn_cnt, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single XOR transaction
    chk_lat = 1'b1;
    send(8'hA5, 8'h3C, 3'd3, 8'h99, 1'b0, 1'b0);
    wait_drain("drain_single");
    chk("txn_cnt_single", txn_cnt, 1);

    // Back-to-back table vectors, latency 2 each -> consecutive outputs
    for (int i = 0; i < 12; i++)
      send(vecs[i].va, vecs[i].vb, vecs[i].vop, vecs[i].res, vecs[i].err, vecs[i].zero);
    wait_drain("drain_table");
    chk("txn_cnt_table", txn_cnt, 13);
    chk_lat = 1'b0;

    // Stall: two accepted, third held while out_ready low
    out_ready = 1'b0;
    p0 = pop_cnt;
    send(8'hF0, 8'h0F, 3'd1, 8'hFF, 1'b0, 1'b0);
    send(8'hF0, 8'h0F, 3'd0, 8'h00, 1'b0, 1'b1);
    a        = 8'hC3;
    b        = 8'h00;
    op       = 3'd2;
    cur_exp  = '{res: 8'h3C, err: 1'b0, zero: 1'b0, cyc: 0};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_result", result, 8'hFF);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    if (!in_ready) @(negedge clk);
    chk("stall_third_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain("drain_stall");
    chk("stall_delivered", pop_cnt - p0, 3);

    // Reset with both stages full: nothing stale may come out
    out_ready = 1'b0;
    send(8'h11, 8'h22, 3'd1, 8'h33, 1'b0, 1'b0);
    send(8'h11, 8'h22, 3'd3, 8'h33, 1'b0, 1'b0);
    chk("full_in_ready", in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_full_out_valid", out_valid, 0);
    chk("rst_full_txn_cnt", txn_cnt, 0);
    chk("rst_full_in_ready", in_ready, 1);
    #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    chk("rst_full_no_output", out_valid, 0);
    #1;

    // Random operands with random backpressure
    fork
      begin
        repeat (300) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 60; i++) begin
          ra  = 8'($urandom);
          rb  = 8'($urandom);
          rop = 3'($urandom_range(0, 7));
          send(ra, rb, rop, ref_op(ra, rb, rop), rop > 3'd5, ref_op(ra, rb, rop) == 8'h00);
        end
      end
    join
    wait_drain("drain_random");

    // txn_cnt wrap after 65536 handshakes from reset
    do_reset();
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 65536; i++)
      send(8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1);
    wait_drain("drain_wrap");
    chk("txn_cnt_wrap", txn_cnt, 0);
    chk("wrap_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time got limit, required completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
